mixcolumn_engine: RTL and testbench

//  Sequential AES MixColumns / InvMixColumns engine for the 128-bit state.

---
 rtl/mixcolumn_engine.sv | 148 ++++++++++++++
 tb/tb_mixcolumn_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixcolumn_engine.sv
// AES MixColumns / InvMixColumns engine for a 128-bit state, COLS_PER_CYCLE columns per cycle.
// Valid/ready on both sides; the direction is latched with each accepted block.
module mixcolumn_engine #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] in_data_i,
   input  logic         in_inv_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] out_data_o,
   output logic         busy_o
);

   // state | meaning
   // IDLE  | waiting for a block, in_ready=1
   // BUSY  | transforming one column group per cycle
   // DONE  | result presented on out_data, waiting for out_ready

   localparam int NGROUPS = 4 / COLS_PER_CYCLE;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mixcolumn_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Products are built from the x2/x4/x8 chain so both directions share one set of doublings.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0]  s  [4];
      logic [7:0]  x2 [4];
      logic [7:0]  x4 [4];
      logic [7:0]  x8 [4];
      logic [7:0]  m0 [4];
      logic [7:0]  m1 [4];
      logic [7:0]  m2 [4];
      logic [7:0]  m3 [4];
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         s[k]  = col[31-8*k -: 8];
         x2[k] = xtime(s[k]);
         x4[k] = xtime(x2[k]);
         x8[k] = xtime(x4[k]);
         if (inv) begin
            m0[k] = x8[k] ^ x4[k] ^ x2[k];
            m1[k] = x8[k] ^ x2[k] ^ s[k];
            m2[k] = x8[k] ^ x4[k] ^ s[k];
            m3[k] = x8[k] ^ s[k];
         end else begin
            m0[k] = x2[k];
            m1[k] = x2[k] ^ s[k];
            m2[k] = s[k];
            m3[k] = s[k];
         end
      end
      for (int row = 0; row < 4; row++) begin
         r[31-8*row -: 8] = m0[row] ^ m1[(row+1)%4] ^ m2[(row+2)%4] ^ m3[(row+3)%4];
      end
      return r;
   endfunction

   logic [1:0]   state_q, state_d;
   logic [127:0] src_q, src_d;
   logic [127:0] acc_q, acc_d;
   logic [127:0] out_q, out_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         mode_q, mode_d;
   logic         accept;
   logic         last_grp;
   int           col_idx;

   assign last_grp = (cnt_q == 2'(NGROUPS - 1));

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      acc_d   = acc_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      accept  = 1'b0;
      col_idx = 0;
      case (state_q)
         ST_IDLE: begin
            accept = in_valid_i;
         end
         ST_BUSY: begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
               col_idx = int'(cnt_q) * COLS_PER_CYCLE + j;
               acc_d[127-32*col_idx -: 32] = mix_col(src_q[127-32*col_idx -: 32], mode_q);
            end
            cnt_d = cnt_q + 2'd1;
            if (last_grp) begin
               out_d   = acc_d;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               state_d = ST_IDLE;
               accept  = in_valid_i;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Pop and push in the same DONE cycle lands here too, keeping one cycle per block.
      if (accept) begin
         src_d   = in_data_i;
         mode_d  = in_inv_i;
         cnt_d   = '0;
         state_d = ST_BUSY;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   assign in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
   assign out_valid_o = (state_q == ST_DONE);
   assign busy_o      = (state_q == ST_BUSY);
   assign out_data_o  = out_q;

endmodule

// File: tb/tb_mixcolumn_engine.sv
// Bench for mixcolumn_engine: three instances (1, 2 and 4 columns per cycle) checked against
// a shift-and-add GF(2^8) reference through a per-instance scoreboard.
module tb_mixcolumn_engine;

   localparam int NDUT   = 3;
   localparam int N_RAND = 2500;

   localparam logic [127:0] VEC_A     = 128'hdb135345_01010101_c6c6c6c6_d4bf5d30;
   localparam logic [127:0] VEC_A_FWD = 128'h8e4da1bc_01010101_c6c6c6c6_046681e5;
   localparam logic [127:0] VEC_B     = {4{32'hf20a225c}};
   localparam logic [127:0] VEC_B_FWD = {4{32'h9fdc589d}};

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [NDUT];
   logic         in_ready  [NDUT];
   logic [127:0] in_data   [NDUT];
   logic         in_inv    [NDUT];
   logic         out_valid [NDUT];
   logic         out_ready [NDUT];
   logic [127:0] out_data  [NDUT];
   logic         busy      [NDUT];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
      logic [7:0]   m [4];
      logic [7:0]   acc;
      logic [127:0] r;
      if (inv) begin
         m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      end else begin
         m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      end
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gmul(m[(k - row + 4) % 4], s[127-32*c-8*k -: 8]);
            r[127-32*c-8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int CPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      localparam int NG  = 4 / CPC;

      logic [127:0] exp_q [$];
      int           acc_q [$];
      int           cyc = 0;
      logic         ov_prev = 1'b0;

      mixcolumn_engine #(.COLS_PER_CYCLE(CPC)) u_dut (
         .clk_i       (clk),
         .rst_i       (rst),
         .in_valid_i  (in_valid[g]),
         .in_ready_o  (in_ready[g]),
         .in_data_i   (in_data[g]),
         .in_inv_i    (in_inv[g]),
         .out_valid_o (out_valid[g]),
         .out_ready_i (out_ready[g]),
         .out_data_o  (out_data[g]),
         .busy_o      (busy[g])
      );

      // Values seen at a falling edge are what the next rising edge acts on.
      always @(negedge clk) begin
         cyc++;
         if (rst) begin
            exp_q.delete();
            acc_q.delete();
            ov_prev = 1'b0;
         end else begin
            if (out_valid[g] && !ov_prev) begin
               check($sformatf("lat_pending%0d", g), acc_q.size() != 0, 1);
               if (acc_q.size() != 0)
                  check($sformatf("latency%0d", g), cyc - acc_q.pop_front(), NG + 1);
            end
            if (out_valid[g] && out_ready[g]) begin
               check($sformatf("sb_pending%0d", g), exp_q.size() != 0, 1);
               if (exp_q.size() != 0)
                  check($sformatf("sb_data%0d", g), out_data[g], exp_q.pop_front());
            end
            if (in_valid[g] && in_ready[g]) begin
               exp_q.push_back(model(in_data[g], in_inv[g]));
               acc_q.push_back(cyc);
            end
            ov_prev = out_valid[g];
         end
      end
   end

   task automatic wait_valid(input int g);
      for (int n = 0; n < 20 && !out_valid[g]; n++) @(negedge clk);
      check($sformatf("wait_valid%0d", g), out_valid[g], 1);
   endtask

   task automatic run_block(input int g, input logic [127:0] d, input logic inv,
                            output logic [127:0] res);
      @(posedge clk); #1;
      in_valid[g] = 1'b1; in_data[g] = d; in_inv[g] = inv; out_ready[g] = 1'b1;
      @(posedge clk); #1;
      in_valid[g] = 1'b0; in_data[g] = ~d; in_inv[g] = ~inv;
      wait_valid(g);
      res = out_data[g];
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure(input int g);
      logic [127:0] held;
      @(posedge clk); #1;
      in_valid[g] = 1'b1; in_data[g] = VEC_A; in_inv[g] = 1'b0; out_ready[g] = 1'b0;
      @(posedge clk); #1;
      in_valid[g] = 1'b0;
      wait_valid(g);
      held = out_data[g];
      check("bp_first", held, VEC_A_FWD);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid[g] = 1'b1;
         in_data[g]  = {$urandom, $urandom, $urandom, $urandom};
         in_inv[g]   = ~in_inv[g];
         @(negedge clk);
         check("bp_valid", out_valid[g], 1);
         check("bp_hold", out_data[g], held);
         check("bp_in_ready", in_ready[g], 0);
      end
      @(posedge clk); #1;
      in_valid[g] = 1'b0; out_ready[g] = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_b2b(input int g, input int ng);
      int t1;
      @(posedge clk); #1;
      in_valid[g] = 1'b1; in_data[g] = VEC_A; in_inv[g] = 1'b0; out_ready[g] = 1'b1;
      @(posedge clk); #1;
      in_data[g] = VEC_B_FWD; in_inv[g] = 1'b1;
      wait_valid(g);
      t1 = g == 0 ? g_dut[0].cyc : g == 1 ? g_dut[1].cyc : g_dut[2].cyc;
      check("b2b_first", out_data[g], VEC_A_FWD);
      check("b2b_in_ready", in_ready[g], 1);
      @(posedge clk); #1;
      in_valid[g] = 1'b0;
      wait_valid(g);
      check("b2b_second", out_data[g], VEC_B);
      check("b2b_spacing", (g == 0 ? g_dut[0].cyc : g == 1 ? g_dut[1].cyc : g_dut[2].cyc) - t1,
            ng + 1);
      @(posedge clk); #1;
   endtask

   task automatic test_reset(input int g);
      logic [127:0] r;
      @(posedge clk); #1;
      in_valid[g] = 1'b1; in_data[g] = VEC_B; in_inv[g] = 1'b0; out_ready[g] = 1'b1;
      @(posedge clk); #1;
      in_valid[g] = 1'b0; rst = 1'b1;
      check("rst_mid_busy", busy[g], 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready[g], 1);
      check("rst_out_valid", out_valid[g], 0);
      check("rst_out_data", out_data[g], 0);
      check("rst_busy", busy[g], 0);
      run_block(g, VEC_B, 1'b0, r);
      check("rst_after", r, VEC_B_FWD);
   endtask

   task automatic rand_run(input int g);
      logic took;
      int   sent;
      took = 1'b1;
      sent = 0;
      for (int c = 0; c < 40000 && sent < N_RAND; c++) begin
         @(posedge clk); #1;
         out_ready[g] = ($urandom_range(3) != 0);
         if (took || !in_valid[g]) begin
            in_valid[g] = ($urandom_range(3) != 0);
            in_data[g]  = {$urandom, $urandom, $urandom, $urandom};
            in_inv[g]   = 1'($urandom_range(1));
         end
         @(negedge clk);
         took = in_valid[g] && in_ready[g];
         if (took) sent++;
      end
      check($sformatf("rand_sent%0d", g), sent, N_RAND);
      @(posedge clk); #1;
      in_valid[g] = 1'b0; out_ready[g] = 1'b1;
      repeat (12) @(posedge clk);
   endtask

   initial begin
      logic [127:0] r;
      logic [127:0] r2;
      rst = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
         in_valid[g] = 1'b0; in_data[g] = '0; in_inv[g] = 1'b0; out_ready[g] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         check("reset_in_ready", in_ready[g], 1);
         check("reset_out_valid", out_valid[g], 0);
         check("reset_busy", busy[g], 0);
         check("reset_out_data", out_data[g], 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      for (int g = 0; g < NDUT; g++) begin
         run_block(g, VEC_A, 1'b0, r);
         check("fwd_a", r, VEC_A_FWD);
         run_block(g, r, 1'b1, r2);
         check("inv_a", r2, VEC_A);
         run_block(g, VEC_B, 1'b0, r);
         check("fwd_b", r, VEC_B_FWD);
         run_block(g, r, 1'b1, r2);
         check("inv_b", r2, VEC_B);
         test_backpressure(g);
         test_b2b(g, 4 / (g == 0 ? 1 : g == 1 ? 2 : 4));
         test_reset(g);
      end

      fork
         rand_run(0);
         rand_run(1);
         rand_run(2);
      join

      check("drain0", g_dut[0].exp_q.size(), 0);
      check("drain1", g_dut[1].exp_q.size(), 0);
      check("drain2", g_dut[2].exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
